// File: rtl/sync_fifo_ctrl_pkg.sv
// Shared definitions for the single-clock FIFO controller family.
// Holds the default geometry and threshold values, the depth helper, and the
// presentation-stage state type used when SYNC_FIFO_FWFT_EN is defined.
package sync_fifo_ctrl_pkg;

  localparam int SFC_ADDR_WIDTH_DEF    = 8;
  localparam int SFC_PROG_FULL_MARGIN  = 4;
  localparam int SFC_PROG_EMPTY_DEF    = 4;

  // Number of RAM entries addressed by an aw-bit address.
  function automatic int fifo_depth(input int aw);
    return 32'sd1 <<< aw;
  endfunction

  // First-word-fall-through presentation stage: nothing shown / word shown.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_VALID = 1'b1
  } fwft_state_e;

endpackage

// File: rtl/fifo_flag_gen.sv
// Combinational FIFO flag decoder.
// Maps an occupancy count (0..DEPTH, ADDR_WIDTH+1 bits) to the standard
// full/empty/almost/programmable flags. All compares are unsigned at the full
// count width so count==DEPTH is never truncated. Shared with the async
// controllers, so it carries no clock and no state.
module fifo_flag_gen
  import sync_fifo_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH        = SFC_ADDR_WIDTH_DEF,
  parameter int PROG_FULL_THRESH  = fifo_depth(ADDR_WIDTH) - SFC_PROG_FULL_MARGIN,
  parameter int PROG_EMPTY_THRESH = SFC_PROG_EMPTY_DEF
) (
  input  logic [ADDR_WIDTH:0] count,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic                prog_full,
  output logic                prog_empty
);

  localparam logic [ADDR_WIDTH:0] ZERO_C  = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0] ONE_C   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AF_C    = DEPTH_C - ONE_C;
  localparam logic [ADDR_WIDTH:0] PF_C    = (ADDR_WIDTH+1)'(PROG_FULL_THRESH);
  localparam logic [ADDR_WIDTH:0] PE_C    = (ADDR_WIDTH+1)'(PROG_EMPTY_THRESH);

  assign full         = (count == DEPTH_C);
  assign empty        = (count == ZERO_C);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= ONE_C);
  assign prog_full    = (count >= PF_C);
  assign prog_empty   = (count <= PE_C);

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO pointer and flag controller for an external
// simple-dual-port RAM with 1-cycle read latency.
// Optional feature macro: SYNC_FIFO_FWFT_EN (first-word-fall-through). When
// undefined, reads are issued on request and rd_valid follows one cycle later.
// All flags and elements are registered from the next-state count, so they are
// current in the cycle after the edge that changed the occupancy.
module sync_fifo_ctrl
  import sync_fifo_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH        = SFC_ADDR_WIDTH_DEF,
  parameter int PROG_FULL_THRESH  = fifo_depth(ADDR_WIDTH) - SFC_PROG_FULL_MARGIN,
  parameter int PROG_EMPTY_THRESH = SFC_PROG_EMPTY_DEF
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  prog_full,
  output logic                  prog_empty,
  output logic [ADDR_WIDTH:0]   elements,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] ZERO_C = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0] ONE_C  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0] wptr_r, rptr_r, count_r, count_nxt_s;
  logic full_r, empty_r, af_r, ae_r, pf_r, pe_r;
  logic overflow_r, underflow_r, rd_valid_r;
  logic wr_acc_s, rd_acc_s, re_s, empty_nxt_s;
  logic f_full_s, f_empty_s, f_af_s, f_ae_s, f_pf_s, f_pe_s;

  assign wr_acc_s = wr_en & ~full_r;

`ifdef SYNC_FIFO_FWFT_EN
  // Words still in RAM exclude the one already held on the RAM output.
  fwft_state_e         state_r;
  logic [ADDR_WIDTH:0] ram_cnt_s;
  logic                ram_has_s, valid_nxt_s;

  assign ram_cnt_s = count_r - {{ADDR_WIDTH{1'b0}}, rd_valid_r};
  assign ram_has_s = (ram_cnt_s != ZERO_C);
  assign rd_acc_s  = rd_en & rd_valid_r;

  // Presentation stage: fetch when idle, refetch on pop so valid stays back-to-back
  always_comb begin
    re_s        = 1'b0;
    valid_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        re_s        = ram_has_s;
        valid_nxt_s = ram_has_s;
      end
      ST_VALID: begin
        if (rd_en) begin
          re_s        = ram_has_s;
          valid_nxt_s = ram_has_s;
        end else begin
          re_s        = 1'b0;
          valid_nxt_s = 1'b1;
        end
      end
      default: begin
        re_s        = 1'b0;
        valid_nxt_s = 1'b0;
      end
    endcase
  end

  // Presentation FSM state and its registered valid output
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r    <= ST_IDLE;
      rd_valid_r <= 1'b0;
    end else begin
      state_r    <= valid_nxt_s ? ST_VALID : ST_IDLE;
      rd_valid_r <= valid_nxt_s;
    end
  end

  // A zero count already implies no presented word; either term alone marks empty
  assign empty_nxt_s = f_empty_s | ~valid_nxt_s;
`else
  assign rd_acc_s    = rd_en & ~empty_r;
  assign re_s        = rd_acc_s;
  assign empty_nxt_s = f_empty_s;

  // Read data appears on the RAM output one cycle after the strobe
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= re_s;
    end
  end
`endif

  // Occupancy after this edge: simultaneous accepted push and pop cancel
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_nxt_s = count_r + ONE_C;
      2'b01:   count_nxt_s = count_r - ONE_C;
      default: count_nxt_s = count_r;
    endcase
  end

  fifo_flag_gen #(
    .ADDR_WIDTH        (ADDR_WIDTH),
    .PROG_FULL_THRESH  (PROG_FULL_THRESH),
    .PROG_EMPTY_THRESH (PROG_EMPTY_THRESH)
  ) u_flag_gen (
    .count        (count_nxt_s),
    .full         (f_full_s),
    .empty        (f_empty_s),
    .almost_full  (f_af_s),
    .almost_empty (f_ae_s),
    .prog_full    (f_pf_s),
    .prog_empty   (f_pe_s)
  );

  // Pointers, occupancy, flags and rejection pulses
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wptr_r      <= ZERO_C;
      rptr_r      <= ZERO_C;
      count_r     <= ZERO_C;
      full_r      <= 1'b0;
      empty_r     <= 1'b1;
      af_r        <= 1'b0;
      ae_r        <= 1'b1;
      pf_r        <= 1'b0;
      pe_r        <= 1'b1;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      wptr_r      <= wptr_r + {{ADDR_WIDTH{1'b0}}, wr_acc_s};
      rptr_r      <= rptr_r + {{ADDR_WIDTH{1'b0}}, re_s};
      count_r     <= count_nxt_s;
      full_r      <= f_full_s;
      empty_r     <= empty_nxt_s;
      af_r        <= f_af_s;
      ae_r        <= f_ae_s;
      pf_r        <= f_pf_s;
      pe_r        <= f_pe_s;
      overflow_r  <= wr_en & ~wr_acc_s;
      underflow_r <= rd_en & ~rd_acc_s;
    end
  end

  assign ram_we       = wr_acc_s;
  assign ram_waddr    = wptr_r[ADDR_WIDTH-1:0];
  assign ram_re       = re_s;
  assign ram_raddr    = rptr_r[ADDR_WIDTH-1:0];
  assign rd_valid     = rd_valid_r;
  assign full         = full_r;
  assign empty        = empty_r;
  assign almost_full  = af_r;
  assign almost_empty = ae_r;
  assign prog_full    = pf_r;
  assign prog_empty   = pe_r;
  assign elements     = count_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Scoreboard bench for sync_fifo_ctrl (ADDR_WIDTH=4, thresholds 12/3).
// The driver applies one directed vector per cycle and pushes the expected
// per-cycle status word plus the expected address of every fetched word. A
// separate monitor pops and compares on the opposite clock edge.
module tb_sync_fifo_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst, wr_en, rd_en;
  logic       ram_we, ram_re, rd_valid;
  logic [3:0] ram_waddr, ram_raddr;
  logic       full, empty, almost_full, almost_empty, prog_full, prog_empty;
  logic [4:0] elements;
  logic       overflow, underflow;

  sync_fifo_ctrl #(
    .ADDR_WIDTH        (4),
    .PROG_FULL_THRESH  (12),
    .PROG_EMPTY_THRESH (3)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .ram_we       (ram_we),
    .ram_waddr    (ram_waddr),
    .ram_re       (ram_re),
    .ram_raddr    (ram_raddr),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .prog_full    (prog_full),
    .prog_empty   (prog_empty),
    .elements     (elements),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 sys_clk = ~sys_clk;

  logic [23:0] exp_q[$];
  logic [3:0]  rd_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        done = 1'b0;

  // Reference state: what the registered outputs should hold this cycle
  logic [4:0] m_cnt = 5'd0;
  logic [4:0] m_w   = 5'd0;
  logic [4:0] m_r   = 5'd0;
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
  logic       m_v   = 1'b0;

  task automatic step(input logic rst, input logic wr, input logic rd);
    logic       fl, em, wa, pop, re, nv;
    logic [4:0] rc;
    sys_rst = rst;
    wr_en   = wr;
    rd_en   = rd;
    fl = (m_cnt == 5'd16);
`ifdef SYNC_FIFO_FWFT_EN
    em  = ~m_v;
    rc  = m_cnt - {4'd0, m_v};
    pop = rd & m_v;
    if (!m_v) begin
      re = (rc != 5'd0);
      nv = (rc != 5'd0);
    end else if (rd) begin
      re = (rc != 5'd0);
      nv = (rc != 5'd0);
    end else begin
      re = 1'b0;
      nv = 1'b1;
    end
`else
    em  = (m_cnt == 5'd0);
    pop = rd & ~em;
    re  = pop;
    nv  = pop;
`endif
    wa = wr & ~fl;
    exp_q.push_back({m_cnt, fl, em, (m_cnt >= 5'd15), (m_cnt <= 5'd1),
                     (m_cnt >= 5'd12), (m_cnt <= 5'd3), m_ovf, m_unf, m_v,
                     wa, m_w[3:0], re, m_r[3:0]});
    if (re && !rst) rd_q.push_back(m_r[3:0]);
    if (rst) begin
      m_cnt = 5'd0; m_w = 5'd0; m_r = 5'd0;
      m_ovf = 1'b0; m_unf = 1'b0; m_v = 1'b0;
    end else begin
      if (wa && !pop) m_cnt = m_cnt + 5'd1;
      else if (pop && !wa) m_cnt = m_cnt - 5'd1;
      else m_cnt = m_cnt;
      if (wa) m_w = m_w + 5'd1;
      if (re) m_r = m_r + 5'd1;
      m_ovf = wr & fl;
      m_unf = rd & ~pop;
      m_v   = nv;
    end
    @(posedge sys_clk);
    #2;
  endtask

  // Monitor: per-cycle status compare and per-fetch data-valid/address compare
  logic [23:0] st_act, st_exp;
  logic [3:0]  a_exp;
  logic        prev_re = 1'b0;
  logic        prev_rst = 1'b1;
  logic [3:0]  prev_addr = 4'd0;

  always @(negedge sys_clk) begin
    if (exp_q.size() > 0) begin
      st_exp = exp_q.pop_front();
      st_act = {elements, full, empty, almost_full, almost_empty, prog_full,
                prog_empty, overflow, underflow, rd_valid, ram_we, ram_waddr,
                ram_re, ram_raddr};
      checks = checks + 1;
      if (st_act !== st_exp) begin
        errors = errors + 1;
        $display("FAIL status t=%0t got %h want %h (elem,full,empty,af,ae,pf,pe,ovf,unf,vld,we,waddr,re,raddr)",
                 $time, st_act, st_exp);
      end
    end
    if (prev_re && !prev_rst) begin
      checks = checks + 1;
      if (rd_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL fetch t=%0t unexpected read of addr %0d", $time, prev_addr);
      end else begin
        a_exp = rd_q.pop_front();
        if (!rd_valid || prev_addr !== a_exp) begin
          errors = errors + 1;
          $display("FAIL fetch t=%0t got valid=%b addr=%0d want valid=1 addr=%0d",
                   $time, rd_valid, prev_addr, a_exp);
        end
      end
    end
    prev_re   = ram_re;
    prev_addr = ram_raddr;
    prev_rst  = sys_rst;
    if (done && exp_q.size() == 0) begin
      checks = checks + 1;
      if (rd_q.size() != 0) begin
        errors = errors + 1;
        $display("FAIL pending_fetch got %0d outstanding want 0", rd_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  // Directed stimulus
  initial begin
    sys_rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    @(posedge sys_clk);
    #2;
    step(1'b1, 1'b0, 1'b0);
    // Fill from reset, then a rejected 17th write
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    // Drain from full, then a rejected read
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    // Simultaneous push/pop at full, empty and mid-level
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1);
    // Address wrap with interleaved pairs
    for (int i = 0; i < 40; i++) begin
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1);
    end
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    // Reset mid-fill with a concurrent write
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    // Single write latency, then 5 words drained with continuous rd_en
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    done = 1'b1;
  end

  // Bound the run in case the monitor never reaches the summary
  initial begin
    #200000;
    $display("FAIL watchdog run did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
